// File: rtl/am2901_pkg.sv
// Shared encodings and sizes for the am2901 bit-slice ALU.
package am2901_pkg;

  localparam int unsigned SLICE_W   = 4;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RAM_DEPTH = 16;

  // Source operand pairs (R,S), microcode field I[2:0]
  localparam logic [2:0] SRC_AQ = 3'd0;
  localparam logic [2:0] SRC_AB = 3'd1;
  localparam logic [2:0] SRC_ZQ = 3'd2;
  localparam logic [2:0] SRC_ZB = 3'd3;
  localparam logic [2:0] SRC_ZA = 3'd4;
  localparam logic [2:0] SRC_DA = 3'd5;
  localparam logic [2:0] SRC_DQ = 3'd6;
  localparam logic [2:0] SRC_DZ = 3'd7;

  // ALU functions, microcode field I[5:3]
  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_SUBR  = 3'd1;
  localparam logic [2:0] FN_SUBS  = 3'd2;
  localparam logic [2:0] FN_OR    = 3'd3;
  localparam logic [2:0] FN_AND   = 3'd4;
  localparam logic [2:0] FN_NOTRS = 3'd5;
  localparam logic [2:0] FN_EXOR  = 3'd6;
  localparam logic [2:0] FN_EXNOR = 3'd7;

  // Destination control, microcode field I[8:6]
  localparam logic [2:0] DST_QREG  = 3'd0;
  localparam logic [2:0] DST_NOP   = 3'd1;
  localparam logic [2:0] DST_RAMA  = 3'd2;
  localparam logic [2:0] DST_RAMF  = 3'd3;
  localparam logic [2:0] DST_RAMQD = 3'd4;
  localparam logic [2:0] DST_RAMD  = 3'd5;
  localparam logic [2:0] DST_RAMQU = 3'd6;
  localparam logic [2:0] DST_RAMU  = 3'd7;

  function automatic logic is_arith_fn(input logic [2:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUBR) || (fn == FN_SUBS);
  endfunction

endpackage

// File: rtl/am2901_alu_core.sv
// Combinational 8-function ALU: (R,S,op,cin) -> F, carry out and signed overflow.
module am2901_alu_core
  import am2901_pkg::*;
#(
  parameter int unsigned WIDTH = SLICE_W
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [2:0]       op_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o,
  output logic             ovr_o
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] low_sum;

  // Subtracts are adds of an inverted operand; low_sum yields the carry into the MSB.
  always_comb begin
    x       = r_i;
    y       = s_i;
    f_o     = '0;
    cout_o  = 1'b0;
    ovr_o   = 1'b0;
    if (op_i == FN_SUBR) x = ~r_i;
    if (op_i == FN_SUBS) y = ~s_i;
    sum     = {1'b0, x} + {1'b0, y} + SUM_W'(cin_i);
    low_sum = {1'b0, x[WIDTH-2:0]} + {1'b0, y[WIDTH-2:0]} + WIDTH'(cin_i);
    if (is_arith_fn(op_i)) begin
      f_o    = sum[WIDTH-1:0];
      cout_o = sum[WIDTH];
      ovr_o  = low_sum[WIDTH-1] ^ sum[WIDTH];
    end else begin
      case (op_i)
        FN_OR:    f_o = r_i | s_i;
        FN_AND:   f_o = r_i & s_i;
        FN_NOTRS: f_o = ~r_i & s_i;
        FN_EXOR:  f_o = r_i ^ s_i;
        default:  f_o = ~(r_i ^ s_i);
      endcase
    end
  end

endmodule

// File: rtl/am2901_slice.sv
// Am2901-style 4-bit ALU slice: 16x4 two-port register file, Q register, source mux,
// ALU and destination/shift control. Define AM2901_SHIFT_IO_EN for shift chaining ports.
module am2901_slice
  import am2901_pkg::*;
#(
  parameter int unsigned WIDTH = SLICE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  input  logic [2:0]        src,
  input  logic [2:0]        op,
  input  logic [2:0]        dest,
  input  logic              cin,
  output logic [WIDTH-1:0]  yout,
  output logic              cout,
  output logic              f0,
  output logic              f3,
  output logic              ovr
`ifdef AM2901_SHIFT_IO_EN
  ,
  input  logic              ram0_in,
  input  logic              ram3_in,
  input  logic              q0_in,
  input  logic              q3_in,
  output logic              ram0_out,
  output logic              ram3_out,
  output logic              q0_out,
  output logic              q3_out
`endif
);

  logic [WIDTH-1:0] ram_q [RAM_DEPTH];
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] s_op;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_we;
  logic             sh_ram0;
  logic             sh_ram3;
  logic             sh_q0;
  logic             sh_q3;

`ifdef AM2901_SHIFT_IO_EN
  assign sh_ram0 = ram0_in;
  assign sh_ram3 = ram3_in;
  assign sh_q0   = q0_in;
  assign sh_q3   = q3_in;

  // Shifted-out bits are only driven while a shift destination is selected.
  always_comb begin
    ram0_out = 1'b0;
    ram3_out = 1'b0;
    q0_out   = 1'b0;
    q3_out   = 1'b0;
    if (dest == DST_RAMQD || dest == DST_RAMD) begin
      ram0_out = f[0];
      q0_out   = q_q[0];
    end else if (dest == DST_RAMQU || dest == DST_RAMU) begin
      ram3_out = f[WIDTH-1];
      q3_out   = q_q[WIDTH-1];
    end
  end
`else
  assign sh_ram0 = 1'b0;
  assign sh_ram3 = 1'b0;
  assign sh_q0   = 1'b0;
  assign sh_q3   = 1'b0;
`endif

  assign a_data = ram_q[a];
  assign b_data = ram_q[b];

  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src)
      SRC_AQ: begin r_op = a_data; s_op = q_q;    end
      SRC_AB: begin r_op = a_data; s_op = b_data; end
      SRC_ZQ: s_op = q_q;
      SRC_ZB: s_op = b_data;
      SRC_ZA: s_op = a_data;
      SRC_DA: begin r_op = din;    s_op = a_data; end
      SRC_DQ: begin r_op = din;    s_op = q_q;    end
      default: r_op = din;
    endcase
  end

  am2901_alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .r_i    (r_op),
    .s_i    (s_op),
    .op_i   (op),
    .cin_i  (cin),
    .f_o    (f),
    .cout_o (cout),
    .ovr_o  (ovr)
  );

  assign f0 = (f == '0);
  assign f3 = f[WIDTH-1];

  // Destination decode: write enables, shifted write data and Y selection.
  always_comb begin
    q_d       = q_q;
    ram_we    = 1'b0;
    ram_wdata = f;
    yout      = f;
    case (dest)
      DST_QREG: q_d = f;
      DST_NOP:  ;
      DST_RAMA: begin ram_we = 1'b1; yout = a_data; end
      DST_RAMF: ram_we = 1'b1;
      DST_RAMQD: begin
        ram_we    = 1'b1;
        ram_wdata = {sh_ram3, f[WIDTH-1:1]};
        q_d       = {sh_q3, q_q[WIDTH-1:1]};
      end
      DST_RAMD: begin
        ram_we    = 1'b1;
        ram_wdata = {sh_ram3, f[WIDTH-1:1]};
      end
      DST_RAMQU: begin
        ram_we    = 1'b1;
        ram_wdata = {f[WIDTH-2:0], sh_ram0};
        q_d       = {q_q[WIDTH-2:0], sh_q0};
      end
      default: begin
        ram_we    = 1'b1;
        ram_wdata = {f[WIDTH-2:0], sh_ram0};
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) ram_q[i] <= '0;
      q_q <= '0;
    end else begin
      q_q <= q_d;
      if (ram_we) ram_q[b] <= ram_wdata;
    end
  end

endmodule

// File: tb/tb_am2901_slice.sv
// Directed self-checking bench for am2901_slice (default build, shift I/O disabled).
module tb_am2901_slice;

  logic       clock;
  logic       reset;
  logic [3:0] din;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] src;
  logic [2:0] op;
  logic [2:0] dest;
  logic       cin;
  logic [3:0] yout;
  logic       cout;
  logic       f0;
  logic       f3;
  logic       ovr;
  logic [7:0] obs;
  int         n_checks;
  int         n_fail;

`ifdef AM2901_SHIFT_IO_EN
  logic ram0_out, ram3_out, q0_out, q3_out;
`endif

  am2901_slice dut (
    .clock (clock),
    .reset (reset),
    .din   (din),
    .a     (a),
    .b     (b),
    .src   (src),
    .op    (op),
    .dest  (dest),
    .cin   (cin),
    .yout  (yout),
    .cout  (cout),
    .f0    (f0),
    .f3    (f3),
    .ovr   (ovr)
`ifdef AM2901_SHIFT_IO_EN
    ,
    .ram0_in  (1'b0),
    .ram3_in  (1'b0),
    .q0_in    (1'b0),
    .q3_in    (1'b0),
    .ram0_out (ram0_out),
    .ram3_out (ram3_out),
    .q0_out   (q0_out),
    .q3_out   (q3_out)
`endif
  );

  // Observed vector layout: {yout[3:0], cout, ovr, f3, f0}
  assign obs = {yout, cout, ovr, f3, f0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive(input logic [2:0] s, input logic [2:0] o, input logic [2:0] d,
                       input logic [3:0] aa, input logic [3:0] bb,
                       input logic [3:0] dd, input logic c);
    src = s; op = o; dest = d; a = aa; b = bb; din = dd; cin = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input logic [3:0] addr, input logic [3:0] val);
    drive(3'd7, 3'd0, 3'd3, 4'd0, addr, val, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3'd1, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0000_0001) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", obs, 8'b0000_0001);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_load_read();
    load(4'd2, 4'd5);
    drive(3'd4, 3'd0, 3'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0101_0000) begin
      n_fail++; $display("FAIL load_read: got %b want %b", obs, 8'b0101_0000);
    end
  endtask

  task automatic test_arith();
    load(4'd1, 4'd9);
    load(4'd2, 4'd7);
    drive(3'd1, 3'd0, 3'd1, 4'd1, 4'd2, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b0001_1000) begin
      n_fail++; $display("FAIL add_9_7_c1: got %b want %b", obs, 8'b0001_1000);
    end
    drive(3'd1, 3'd2, 3'd1, 4'd1, 4'd2, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b0010_1100) begin
      n_fail++; $display("FAIL subs_9_7: got %b want %b", obs, 8'b0010_1100);
    end
    drive(3'd1, 3'd1, 3'd1, 4'd1, 4'd2, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b1110_0110) begin
      n_fail++; $display("FAIL subr_9_7: got %b want %b", obs, 8'b1110_0110);
    end
    drive(3'd5, 3'd0, 3'd1, 4'd2, 4'd0, 4'd1, 1'b0);
    n_checks++;
    if (obs !== 8'b1000_0110) begin
      n_fail++; $display("FAIL add_overflow: got %b want %b", obs, 8'b1000_0110);
    end
  endtask

  task automatic test_q_shift();
    drive(3'd7, 3'd0, 3'd0, 4'd0, 4'd0, 4'd6, 1'b0);
    tick();
    drive(3'd2, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0110_0000) begin
      n_fail++; $display("FAIL q_load: got %b want %b", obs, 8'b0110_0000);
    end
    drive(3'd2, 3'd0, 3'd4, 4'd0, 4'd3, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0110_0000) begin
      n_fail++; $display("FAIL ramqd_y: got %b want %b", obs, 8'b0110_0000);
    end
    tick();
    drive(3'd2, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0011_0000) begin
      n_fail++; $display("FAIL ramqd_q: got %b want %b", obs, 8'b0011_0000);
    end
    drive(3'd4, 3'd0, 3'd1, 4'd3, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0011_0000) begin
      n_fail++; $display("FAIL ramqd_ram: got %b want %b", obs, 8'b0011_0000);
    end
    drive(3'd2, 3'd0, 3'd6, 4'd0, 4'd4, 4'd0, 1'b0);
    tick();
    drive(3'd2, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0110_0000) begin
      n_fail++; $display("FAIL ramqu_q: got %b want %b", obs, 8'b0110_0000);
    end
    drive(3'd4, 3'd0, 3'd1, 4'd4, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0110_0000) begin
      n_fail++; $display("FAIL ramqu_ram: got %b want %b", obs, 8'b0110_0000);
    end
  endtask

  task automatic test_rama();
    drive(3'd7, 3'd0, 3'd2, 4'd1, 4'd5, 4'hA, 1'b0);
    n_checks++;
    if (obs !== 8'b1001_0010) begin
      n_fail++; $display("FAIL rama_y: got %b want %b", obs, 8'b1001_0010);
    end
    tick();
    drive(3'd4, 3'd0, 3'd1, 4'd5, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b1010_0010) begin
      n_fail++; $display("FAIL rama_write: got %b want %b", obs, 8'b1010_0010);
    end
  endtask

  task automatic test_logic();
    load(4'd6, 4'hC);
    load(4'd7, 4'hA);
    drive(3'd1, 3'd3, 3'd1, 4'd6, 4'd7, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b1110_0010) begin
      n_fail++; $display("FAIL or: got %b want %b", obs, 8'b1110_0010);
    end
    drive(3'd1, 3'd4, 3'd1, 4'd6, 4'd7, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b1000_0010) begin
      n_fail++; $display("FAIL and: got %b want %b", obs, 8'b1000_0010);
    end
    drive(3'd1, 3'd5, 3'd1, 4'd6, 4'd7, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b0010_0000) begin
      n_fail++; $display("FAIL notrs: got %b want %b", obs, 8'b0010_0000);
    end
    drive(3'd1, 3'd6, 3'd1, 4'd6, 4'd7, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b0110_0000) begin
      n_fail++; $display("FAIL exor: got %b want %b", obs, 8'b0110_0000);
    end
    drive(3'd1, 3'd7, 3'd1, 4'd6, 4'd7, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b1001_0010) begin
      n_fail++; $display("FAIL exnor: got %b want %b", obs, 8'b1001_0010);
    end
    drive(3'd1, 3'd6, 3'd1, 4'd6, 4'd6, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b0000_0001) begin
      n_fail++; $display("FAIL exor_equal: got %b want %b", obs, 8'b0000_0001);
    end
  endtask

  task automatic test_read_before_write();
    drive(3'd4, 3'd0, 3'd3, 4'd1, 4'd1, 4'd0, 1'b1);
    n_checks++;
    if (obs !== 8'b1010_0010) begin
      n_fail++; $display("FAIL rbw_pre_edge: got %b want %b", obs, 8'b1010_0010);
    end
    tick();
    #1;
    n_checks++;
    if (obs !== 8'b1011_0010) begin
      n_fail++; $display("FAIL rbw_post_edge: got %b want %b", obs, 8'b1011_0010);
    end
  endtask

  task automatic test_async_reset();
    drive(3'd4, 3'd0, 3'd1, 4'd1, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b1010_0010) begin
      n_fail++; $display("FAIL pre_reset: got %b want %b", obs, 8'b1010_0010);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 8'b0000_0001) begin
      n_fail++; $display("FAIL async_ram: got %b want %b", obs, 8'b0000_0001);
    end
    drive(3'd2, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0000_0001) begin
      n_fail++; $display("FAIL async_q: got %b want %b", obs, 8'b0000_0001);
    end
    drive(3'd1, 3'd0, 3'd1, 4'd5, 4'd7, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0000_0001) begin
      n_fail++; $display("FAIL async_ab: got %b want %b", obs, 8'b0000_0001);
    end
    @(negedge clock);
    reset = 1'b0;
    load(4'd2, 4'd3);
    drive(3'd4, 3'd0, 3'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    n_checks++;
    if (obs !== 8'b0011_0000) begin
      n_fail++; $display("FAIL post_reset_load: got %b want %b", obs, 8'b0011_0000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    src = '0; op = '0; dest = 3'd1; a = '0; b = '0; din = '0; cin = 1'b0;
    test_reset();
    test_load_read();
    test_arith();
    test_q_shift();
    test_rama();
    test_logic();
    test_read_before_write();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
